// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract unit: one 4-bit carry-lookahead slice reused across
// WIDTH/4 clock cycles, with the inter-nibble carry held in a register.

module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sign_a;
    logic             sign_b;
    logic             accept;
    logic             last_slice;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    cla u_cla (
        .a    (op_a[3:0]),
        .b    (op_b[3:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign accept     = (state == IDLE) && in_valid;
    assign last_slice = (cnt == CW'(N - 1));

    // Result fills from the top so the first (least significant) nibble ends
    // up at bit 0 after N shifts; written this way to stay legal for WIDTH=4.
    always_comb begin
        res_next             = res >> 4;
        res_next[WIDTH-1 -: 4] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        sum       = '0;
        cout      = 1'b0;
        overflow  = 1'b0;
        if (state == DONE) begin
            sum      = res;
            cout     = carry;
            overflow = (sign_a == sign_b) && (res[WIDTH-1] != sign_a);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else if (accept) begin
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            sign_a <= a[WIDTH-1];
            sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt    <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 4;
            op_b  <= op_b >> 4;
            res   <= res_next;
            carry <= slice_cout;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16) with an expected-result
// queue filled on acceptance and drained on each output handshake.

module tb_nibble_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic s);
        exp_t        e;
        int          r;
        logic [16:0] u;
        if (s) begin
            r      = int'($signed(x)) - int'($signed(y));
            e.sum  = x - y;
            e.cout = (x >= y);
        end else begin
            r      = int'($signed(x)) + int'($signed(y)) + int'(ci);
            u      = {1'b0, x} + {1'b0, y} + 17'(ci);
            e.sum  = u[15:0];
            e.cout = u[16];
        end
        e.ovf = (r > 32767) || (r < -32768);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a bundle at a negedge, accept it on the following posedge.
    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic s);
        @(negedge clk);
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(x, y, ci, s));
        #1 in_valid = 1'b0;
    endtask

    // Wait for out_valid, check latency and values, hold for 'hold' cycles,
    // then handshake and confirm return to idle.
    task automatic collect(input string tag, input int hold);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        if (sb_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            for (int i = 0; i <= hold; i++) begin
                chk({tag, "_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_sum"}, 32'(sum), 32'(e.sum));
                chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
                chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
                chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
                if (i < hold) @(negedge clk);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_post_sum"}, 32'(sum), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        issue(16'h1234, 16'h4321, 1'b0, 1'b0);  collect("add_basic", 0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);  collect("add_ripple", 0);
        issue(16'h0000, 16'hFFFF, 1'b1, 1'b0);  collect("add_ripple_cin", 0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);  collect("add_ovf", 0);
        issue(16'h0005, 16'h0007, 1'b1, 1'b1);  collect("sub_neg", 0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);  collect("sub_ovf", 0);
        issue(16'hA5C3, 16'h5A3C, 1'b1, 1'b0);  collect("add_mixed", 0);

        // Backpressure with a second bundle waiting upstream.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        a = 16'h0F0F; b = 16'h0101; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
        collect("bp_first", 3);
        sb_q.push_back(model(16'h0F0F, 16'h0101, 1'b1, 1'b1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect("bp_second", 0);

        // Reset during RUN aborts the operation.
        issue(16'h1357, 16'h2468, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        void'(sb_q.pop_back());
        repeat (3) @(negedge clk);
        chk("abort_hold_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);  collect("after_abort", 0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
